// File: rtl/fpu_addsub_p.sv
// fpu_addsub_p: sequential floating-point adder/subtractor with a start/done handshake.
//   Word format {sign, exp[EXP_W-1:0], frac[MAN_W-1:0]}. Exponent 0 encodes zero and
//   all-ones encodes overflow. Rounding is round-to-nearest-even, and underflow is
//   flushed to zero.
// Ports:
//   clock100KHz  rising-edge clock
//   reset        synchronous, active-high
//   start        request, sampled only while idle
//   op_sub       0 = A+B, 1 = A-B (captured with the operands)
//   op_A_in      operand A
//   op_B_in      operand B
//   busy         high in every state except idle
//   done         one-cycle pulse when a result is written
//   data_out     result, held until the next done
//   status_out   one-hot: 0001 exact, 0010 inexact, 0100 overflow, 1000 underflow
module fpu_addsub_p #(
  parameter int unsigned EXP_W = 6,
  parameter int unsigned MAN_W = 25,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clock100KHz,
  input  logic         reset,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);

  localparam int unsigned XW = MAN_W + 4;  // hidden + frac + G,R,S
  localparam int unsigned SW = MAN_W + 5;  // XW plus carry
  localparam logic [EXP_W-1:0] MAX_SH  = EXP_W'(MAN_W + 3);
  localparam logic [EXP_W:0]   EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]   EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StAlign, StAddSub, StNorm, StRound, StFinal} state_e;

  state_e           state_q;
  logic [W-1:0]     a_q, b_q;  // b_q holds B with its sign already inverted for subtract
  logic [XW-1:0]    sig_big_q, sig_small_q;
  logic             sign_big_q, sign_small_q, sign_q;
  logic [EXP_W:0]   exp_q;  // one extra bit so increments past all-ones never wrap
  logic [SW-1:0]    sum_q;
  logic [MAN_W-1:0] frac_q;
  logic             unf_q, ovf_in_q, ovf_sign_q, inexact_q;
  logic             done_q;
  logic [W-1:0]     data_q;
  logic [3:0]       status_q;

  // Operand fields
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_sig, b_sig;

  assign a_sign = a_q[W-1];
  assign b_sign = b_q[W-1];
  assign a_exp  = a_q[W-2 -: EXP_W];
  assign b_exp  = b_q[W-2 -: EXP_W];
  assign a_sig  = (a_exp != '0) ? {1'b1, a_q[MAN_W-1:0]} : '0;
  assign b_sig  = (b_exp != '0) ? {1'b1, b_q[MAN_W-1:0]} : '0;

  // Alignment: the operand with the larger exponent is kept, the other is shifted right
  // with every bit that falls past S folded into S.
  logic             a_big;
  logic [EXP_W-1:0] exp_big, exp_diff;
  logic [MAN_W:0]   sig_small;
  logic [XW-1:0]    small_ext, small_shift, lost_mask;

  always_comb begin
    a_big     = (a_exp >= b_exp);
    exp_big   = a_big ? a_exp : b_exp;
    exp_diff  = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
    sig_small = a_big ? b_sig : a_sig;
    small_ext = {sig_small, 3'b000};
    lost_mask = ~({XW{1'b1}} << exp_diff);
    if (exp_diff > MAX_SH) begin
      small_shift    = '0;
      small_shift[0] = |sig_small;
    end else begin
      small_shift    = small_ext >> exp_diff;
      small_shift[0] = small_shift[0] | (|(small_ext & lost_mask));
    end
  end

  // Round to nearest even on the normalised significand.
  logic [MAN_W:0]   mant;
  logic             round_up;
  logic [MAN_W+1:0] mant_rnd;

  always_comb begin
    mant     = sum_q[SW-2:3];
    round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    mant_rnd = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, round_up};
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      sig_big_q    <= '0;
      sig_small_q  <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      sum_q        <= '0;
      frac_q       <= '0;
      unf_q        <= 1'b0;
      ovf_in_q     <= 1'b0;
      ovf_sign_q   <= 1'b0;
      inexact_q    <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
      status_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= op_A_in;
            b_q     <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
            state_q <= StAlign;
          end
        end
        StAlign: begin
          exp_q        <= {1'b0, exp_big};
          sig_big_q    <= {(a_big ? a_sig : b_sig), 3'b000};
          sig_small_q  <= small_shift;
          sign_big_q   <= a_big ? a_sign : b_sign;
          sign_small_q <= a_big ? b_sign : a_sign;
          ovf_in_q     <= (a_exp == '1) | (b_exp == '1);
          ovf_sign_q   <= (a_exp == '1) ? a_sign : b_sign;
          unf_q        <= 1'b0;
          state_q      <= StAddSub;
        end
        StAddSub: begin
          // With equal exponents the "small" operand can be the larger magnitude.
          if (sign_big_q == sign_small_q) begin
            sum_q  <= {1'b0, sig_big_q} + {1'b0, sig_small_q};
            sign_q <= sign_big_q;
          end else if (sig_big_q >= sig_small_q) begin
            sum_q  <= {1'b0, sig_big_q - sig_small_q};
            sign_q <= sign_big_q;
          end else begin
            sum_q  <= {1'b0, sig_small_q - sig_big_q};
            sign_q <= sign_small_q;
          end
          state_q <= StNorm;
        end
        StNorm: begin
          if (sum_q == '0) begin
            sign_q  <= 1'b0;
            exp_q   <= '0;
            state_q <= StRound;
          end else if (sum_q[SW-1]) begin
            sum_q <= {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
            exp_q <= exp_q + 1'b1;
          end else if (!sum_q[SW-2]) begin
            if (exp_q == EXP_ONE) begin
              sum_q   <= '0;
              exp_q   <= '0;
              sign_q  <= 1'b0;
              unf_q   <= 1'b1;
              state_q <= StRound;
            end else begin
              sum_q <= sum_q << 1;
              exp_q <= exp_q - 1'b1;
            end
          end else begin
            state_q <= StRound;
          end
        end
        StRound: begin
          inexact_q <= |sum_q[2:0];
          if (mant_rnd[MAN_W+1]) begin
            frac_q <= mant_rnd[MAN_W:1];
            exp_q  <= exp_q + 1'b1;
          end else begin
            frac_q <= mant_rnd[MAN_W-1:0];
          end
          state_q <= StFinal;
        end
        StFinal: begin
          if (ovf_in_q || (exp_q >= EXP_MAX)) begin
            data_q   <= {(ovf_in_q ? ovf_sign_q : sign_q), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            status_q <= 4'b0100;
          end else if (unf_q) begin
            data_q   <= '0;
            status_q <= 4'b1000;
          end else begin
            data_q   <= {sign_q, exp_q[EXP_W-1:0], frac_q};
            status_q <= inexact_q ? 4'b0010 : 4'b0001;
          end
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_fpu_addsub_p.sv
// tb_fpu_addsub_p: directed and randomised checks of fpu_addsub_p against an exact-arithmetic
// reference model (operands expanded to wide integers, summed exactly, then rounded).
module tb_fpu_addsub_p;

  localparam int EXP_W = 6;
  localparam int MAN_W = 25;
  localparam int W     = 32;

  logic          clock100KHz = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          op_sub = 1'b0;
  logic [W-1:0]  op_A_in = '0;
  logic [W-1:0]  op_B_in = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  data_out;
  logic [3:0]    status_out;

  int vectors = 0;
  int miscompares = 0;

  fpu_addsub_p #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clock100KHz(clock100KHz),
    .reset      (reset),
    .start      (start),
    .op_sub     (op_sub),
    .op_A_in    (op_A_in),
    .op_B_in    (op_B_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clock100KHz = ~clock100KHz;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Exact reference: each operand becomes an integer in units of 2^(1-BIAS-MAN_W).
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, output logic [W-1:0] d,
                                    output logic [3:0] st);
    logic         sa, sb, sign, inexact;
    int           ea, eb, p, e, sh;
    logic [127:0] ma, mb, mag, mant, rem, half;
    sa = a[W-1];
    sb = b[W-1] ^ sub;
    ea = int'(a[W-2 -: EXP_W]);
    eb = int'(b[W-2 -: EXP_W]);
    if (ea == 63 || eb == 63) begin
      d  = {(ea == 63) ? sa : sb, 6'h3f, 25'h0};
      st = 4'b0100;
      return;
    end
    ma = (ea == 0) ? 128'd0 : (128'({1'b1, a[MAN_W-1:0]}) << (ea - 1));
    mb = (eb == 0) ? 128'd0 : (128'({1'b1, b[MAN_W-1:0]}) << (eb - 1));
    if (sa == sb) begin
      mag = ma + mb; sign = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; sign = sa;
    end else begin
      mag = mb - ma; sign = sb;
    end
    if (mag == 0) begin
      d = '0; st = 4'b0001;
      return;
    end
    p = -1;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = p - MAN_W + 1;
    if (e < 1) begin
      d = '0; st = 4'b1000;
      return;
    end
    sh      = p - MAN_W;
    mant    = mag >> sh;
    rem     = mag & ((128'd1 << sh) - 128'd1);
    inexact = (rem != 0);
    if (sh > 0) begin
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 128'd1;
    end
    if (mant[MAN_W+1]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 63) begin
      d = {sign, 6'h3f, 25'h0}; st = 4'b0100;
    end else begin
      d  = {sign, 6'(e), mant[MAN_W-1:0]};
      st = inexact ? 4'b0010 : 4'b0001;
    end
  endfunction

  // Drives a request now, waits for done with a bounded cycle budget.
  // lat = number of rising edges from the accepting edge to the one that raises done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] d, output logic [3:0] st, output int lat);
    start   = 1'b1;
    op_A_in = a;
    op_B_in = b;
    op_sub  = s;
    @(posedge clock100KHz); #1;
    start   = 1'b0;
    op_A_in = $urandom;
    op_B_in = $urandom;
    op_sub  = 1'($urandom);
    lat = 0;
    while (!done && lat < 80) begin
      @(posedge clock100KHz); #1;
      lat++;
    end
    check("done_timeout", {63'd0, done}, 64'd1);
    d  = data_out;
    st = status_out;
  endtask

  task automatic op_vs_model(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s);
    logic [W-1:0] d, ed;
    logic [3:0]   st, est;
    int           lat;
    ref_model(a, b, s, ed, est);
    do_op(a, b, s, d, st, lat);
    check({tag, "_data"}, 64'(d), 64'(ed));
    check({tag, "_status"}, 64'(st), 64'(est));
  endtask

  initial begin
    logic [W-1:0] d;
    logic [3:0]   st;
    int           lat, ndone;

    // Reset state
    repeat (3) @(posedge clock100KHz);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_status", 64'(status_out), 64'd0);
    reset = 1'b0;
    @(posedge clock100KHz); #1;

    // 1.0 + 1.0 with carry normalisation
    do_op(32'h3E000000, 32'h3E000000, 1'b0, d, st, lat);
    check("one_plus_one_data", 64'(d), 64'h40000000);
    check("one_plus_one_status", 64'(st), 64'h1);
    check("one_plus_one_latency", 64'(lat), 64'd6);
    check("done_cycle_busy", 64'(busy), 64'd0);
    @(posedge clock100KHz); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("data_held", 64'(data_out), 64'h40000000);

    do_op(32'h3E000000, 32'h3E000000, 1'b1, d, st, lat);
    check("cancel_data", 64'(d), 64'h0);
    check("cancel_status", 64'(st), 64'h1);

    do_op(32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, d, st, lat);
    check("ovf_data", 64'(d), 64'h7E000000);
    check("ovf_status", 64'(st), 64'h4);

    do_op(32'h3E000000, 32'h08000000, 1'b0, d, st, lat);
    check("rnd_below_data", 64'(d), 64'h3E000000);
    check("rnd_below_status", 64'(st), 64'h2);
    check("rnd_below_latency", 64'(lat), 64'd5);

    do_op(32'h3E000000, 32'h0A000000, 1'b0, d, st, lat);
    check("tie_even_data", 64'(d), 64'h3E000000);
    check("tie_even_status", 64'(st), 64'h2);

    do_op(32'h3E000001, 32'h0A000000, 1'b0, d, st, lat);
    check("tie_odd_data", 64'(d), 64'h3E000002);
    check("tie_odd_status", 64'(st), 64'h2);

    do_op(32'h02000001, 32'h02000000, 1'b1, d, st, lat);
    check("unf_data", 64'(d), 64'h0);
    check("unf_status", 64'(st), 64'h8);

    do_op(32'h7E000000, 32'h3E000000, 1'b0, d, st, lat);
    check("ovf_in_data", 64'(d), 64'h7E000000);
    check("ovf_in_status", 64'(st), 64'h4);

    // Back-to-back: second request driven during the done cycle of the first
    do_op(32'h3E000000, 32'h3E000000, 1'b0, d, st, lat);
    do_op(32'h3E000001, 32'h0A000000, 1'b0, d, st, lat);
    check("b2b_data", 64'(d), 64'h3E000002);
    check("b2b_status", 64'(st), 64'h2);
    check("b2b_latency", 64'(lat), 64'd5);
    @(posedge clock100KHz); #1;

    // start while busy is ignored
    start = 1'b1; op_A_in = 32'h3E000000; op_B_in = 32'h3E000000; op_sub = 1'b0;
    @(posedge clock100KHz); #1;
    start = 1'b0;
    @(posedge clock100KHz); #1;
    start = 1'b1; op_A_in = 32'h40000000; op_B_in = 32'h3E000000; op_sub = 1'b1;
    @(posedge clock100KHz); #1;
    start = 1'b0;
    ndone = 0;
    d = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock100KHz); #1;
      if (done) begin
        ndone++;
        d = data_out;
      end
    end
    check("busy_start_done_count", 64'(ndone), 64'd1);
    check("busy_start_data", 64'(d), 64'h40000000);

    // Reset during a long NORM sequence
    start = 1'b1; op_A_in = 32'h3E000001; op_B_in = 32'h3E000000; op_sub = 1'b1;
    @(posedge clock100KHz); #1;
    start = 1'b0;
    repeat (4) @(posedge clock100KHz);
    #1;
    reset = 1'b1;
    @(posedge clock100KHz); #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_data", 64'(data_out), 64'd0);
    check("mid_rst_status", 64'(status_out), 64'd0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock100KHz); #1;
      if (done) ndone++;
    end
    check("mid_rst_no_done", 64'(ndone), 64'd0);

    op_vs_model("long_norm", 32'h3E000001, 32'h3E000000, 1'b1);

    // Randomised operands against the exact model
    for (int i = 0; i < 250; i++) begin
      int ea, eb, mode;
      logic [W-1:0] a, b;
      logic [31:0] fa, fb;
      mode = int'($urandom_range(0, 4));
      ea   = int'($urandom_range(1, 62));
      fa   = $urandom;
      fb   = $urandom;
      case (mode)
        0: eb = int'($urandom_range(0, 62));
        1: eb = ea + int'($urandom_range(0, 6)) - 3;
        2: begin
          eb = ea;
          fb = fa ^ (32'd1 << $urandom_range(0, 4));
        end
        3: eb = ea - int'($urandom_range(24, 31));
        default: eb = ($urandom_range(0, 1) == 0) ? 0 : ea + 1;
      endcase
      if (eb < 0) eb = 0;
      if (eb > 62) eb = 62;
      a = {1'($urandom), 6'(ea), fa[MAN_W-1:0]};
      b = {1'($urandom), 6'(eb), fb[MAN_W-1:0]};
      if ($urandom_range(0, 1) == 1) op_vs_model("rand", b, a, 1'($urandom));
      else op_vs_model("rand", a, b, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_p.md
# fpu_addsub_p

Parametrised sequential floating-point adder/subtractor with a start/done handshake. Successor to the fixed 32-bit FPU adder: exponent and mantissa widths are configurable, and it adds a subtract mode, round-to-nearest-even using guard/round/sticky bits, and flush-to-zero underflow handling. The one-hot status encoding is unchanged, so downstream status decoding is reused as is.

## Interface
- EXP_W, 6, exponent field width; BIAS = 2^(EXP_W-1)-1
- MAN_W, 25, stored fraction width; word width W = 1+EXP_W+MAN_W (32 at defaults)
- clock100KHz  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op_sub  in  1  0 = A+B, 1 = A-B; captured with operands
- op_A_in  in  W  operand A {sign, exp, frac}
- op_B_in  in  W  operand B
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a result is written
- data_out  out  W  result, held until the next done
- status_out  out  4  one-hot: 0001 EXACT, 0010 INEXACT, 0100 OVERFLOW, 1000 UNDERFLOW

## Operation
- Format: exp field 0 means zero, with the fraction ignored (no denormals). Exp all-ones is the overflow encoding. Significand = {1, frac}.
- An input with exp all-ones forces result OVERFLOW.
- op_sub inverts the captured sign of B.
- FSM: IDLE -> ALIGN -> ADDSUB -> NORM (loops) -> ROUND -> FINAL -> IDLE.
- IDLE: when start=1, capture op_A_in, op_B_in and op_sub, then go to ALIGN. Inputs may change afterwards.
- ALIGN:
  - The larger exponent becomes exp_r.
  - The smaller operand's significand is extended by 3 bits (G, R, S) and shifted right by the exponent difference.
  - All bits shifted past S are ORed into S.
  - A difference > MAN_W+3 yields a significand of 0 and S = OR of the whole shifted significand.
- ADDSUB: MAN_W+5-bit magnitude add (equal signs) or larger-minus-smaller (different signs). Result sign = sign of the larger magnitude.
- NORM: one action per cycle.
  - All-zero (including GRS): result +0, exp 0, go to ROUND.
  - Carry bit set: shift right 1, carry the lost bit into S, exp_r+1, stay.
  - Hidden bit clear: if exp_r == 1, flush to zero and set the underflow flag; otherwise shift left 1 and exp_r-1, stay.
  - Otherwise go to ROUND.
- ROUND:
  - Inexact = G|R|S.
  - Round up when G & (R | S | LSB).
  - A rounding carry-out renormalises with exp_r+1.
- FINAL:
  - If exp_r reaches 2^EXP_W-1 at any point: data_out = {sign, all-ones, 0}, overflow.
  - Write data_out and status_out, pulse done, return to IDLE.
  - Status priority: OVERFLOW > UNDERFLOW > INEXACT > EXACT.
  - An underflow result is {0, 0, 0}.
- Exact cancellation gives +0 with EXACT. The zero sign is always 0.

## Timing
- Reset: state IDLE, busy 0, done 0, data_out 0, status_out 0. A reset mid-operation aborts the operation with no done pulse.
- Start is accepted on edge E0. done is high in the cycle after edge E5 when NORM takes a single cycle.
- Each additional NORM cycle (right shift or left shift) adds 1 cycle. Worst case is 5 + MAN_W + 4.
- done is high for exactly one cycle, with state IDLE and busy 0.
- A start during the done cycle is accepted, giving back-to-back operation.
- start while busy is ignored and not queued.
- data_out and status_out change only on the done edge or on reset.

## Test plan
- 0x3E000000 + 0x3E000000 (1.0+1.0), op_sub=0 -> data_out 0x40000000, status 0001, done 6 cycles after accept (carry adds one NORM cycle).
- 0x3E000000 - 0x3E000000, op_sub=1 -> 0x00000000, status 0001.
- 0x7DFFFFFF + 0x7DFFFFFF -> 0x7E000000, status 0100.
- Rounding:
  - 0x3E000000 + 0x08000000 (2^-27) -> 0x3E000000, status 0010.
  - 0x3E000000 + 0x0A000000 (tie, even LSB) -> 0x3E000000, status 0010.
  - 0x3E000001 + 0x0A000000 (tie, odd LSB) -> 0x3E000002, status 0010.
- 0x02000001 - 0x02000000 -> 0x00000000, status 1000.
- Control:
  - start pulsed while busy -> ignored, exactly one done.
  - reset asserted in NORM -> no done, all outputs 0.
  - start in the done cycle -> second result correct.
